rom_burst: RTL and testbench
============================

ROM_BURST -- requirements
Module: rom_burst

Interface
REQ-001 SHALL have parameter ANCHO, default 8, data word width in bits.
REQ-002 SHALL have parameter PROFUNDIDAD, default 11, number of ROM words.
REQ-003 SHALL have parameter AW, default 8, address width in bits.
REQ-004 SHALL have parameter LW, default 8, burst-length width in bits.
REQ-005 SHALL have parameter MODO_WRAP, default 0: 1 = addresses wrap modulo PROFUNDIDAD, 0 = out-of-range addresses flag an error.
REQ-006 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have ports: rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports: inicio  input  1  burst start request, sampled in IDLE only.
REQ-009 SHALL have ports: direccion  input  AW  burst base address, captured with inicio.
REQ-010 SHALL have ports: longitud  input  LW  beat count, captured with inicio.
REQ-011 SHALL have ports: listo  input  1  consumer ready.
REQ-012 SHALL have ports: datos_s  output  ANCHO  registered ROM word.
REQ-013 SHALL have ports: valido  output  1  datos_s holds a beat.
REQ-014 SHALL have ports: fin  output  1  current beat is last of burst.
REQ-015 SHALL have ports: ocupado  output  1  burst in progress.
REQ-016 SHALL have ports: error  output  1  sticky out-of-range flag.

Function
REQ-017 SHALL hold ROM contents, default table words 0..10 = 95,90,96,98,93,94,97,103,56,97,77 (decimal); words at index >=11 read 0.
REQ-018 SHALL implement FSM states IDLE, LEER, SALIDA.
REQ-019 IDLE: inicio=1 and longitud!=0 -> capture direccion/longitud, clear error, ocupado=1, go LEER; longitud=0 -> stay IDLE, no effect.
REQ-020 LEER: registered ROM read of current address (1-cycle latency) -> SALIDA next cycle with valido=1.
REQ-021 SALIDA: hold datos_s, valido, fin stable while listo=0.
REQ-022 SALIDA with listo=1: beat accepted; if last beat -> IDLE, ocupado=0, valido=0; else address+1, remaining-1, -> LEER.
REQ-023 fin SHALL be 1 exactly while valido=1 on the final beat.
REQ-024 inicio during LEER/SALIDA SHALL be ignored.
REQ-025 MODO_WRAP=1: address >= PROFUNDIDAD SHALL wrap to address-PROFUNDIDAD; error stays 0.
REQ-026 MODO_WRAP=0: beat at address >= PROFUNDIDAD SHALL output 0 and set error, held until next accepted inicio or reset; burst still completes its full count.
REQ-027 Address counter SHALL be AW bits and wrap 2^AW-1 -> 0 in either mode.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, datos_s=0, valido=0, fin=0, ocupado=0, error=0, counters 0.
REQ-029 Reset mid-burst SHALL abort the burst; no beat is delivered after reset deasserts until a new inicio.

Configuration
REQ-030 Macro ROM_BURST_SUMA_EN defined: SHALL add output port suma, 16 bits, running sum modulo 2^16 of accepted beat data, cleared on accepted inicio and reset, updated the cycle after acceptance.
REQ-031 Macro ROM_BURST_SUMA_EN undefined: port suma and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, then inicio, direccion=0, longitud=3, listo=1 -> beats 95,90,96; fin on 96 only; ocupado low after.
REQ-033 direccion=6, longitud=2, listo low 5 cycles on beat 1 -> datos_s=97 stable with valido=1 during stall, then 103 with fin=1.
REQ-034 MODO_WRAP=0, direccion=9, longitud=4 -> beats 97,77,0,0; error=1 from third beat, held after burst.
REQ-035 MODO_WRAP=1, direccion=9, longitud=4 -> beats 97,77,95,90; error=0.
REQ-036 rst_n low during second beat of a 5-beat burst -> all outputs 0 next cycle; inicio with longitud=0 afterwards -> stays IDLE.
REQ-037 ROM_BURST_SUMA_EN defined, direccion=0, longitud=11 -> suma=996 after final acceptance.

Source files
------------

// File: rtl/rom_burst.sv
// Burst reader over a small constant ROM with a ready/valid beat handshake.
// Optional ROM_BURST_SUMA_EN adds a 16-bit running sum of accepted beats.
module rom_burst #(
   parameter int ANCHO       = 8,
   parameter int PROFUNDIDAD = 11,
   parameter int AW          = 8,
   parameter int LW          = 8,
   parameter int MODO_WRAP   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inicio,
   input  logic [AW-1:0]    direccion,
   input  logic [LW-1:0]    longitud,
   input  logic             listo,
   output logic [ANCHO-1:0] datos_s,
   output logic             valido,
   output logic             fin,
   output logic             ocupado,
   output logic             error
`ifdef ROM_BURST_SUMA_EN
   ,
   output logic [15:0]      suma
`endif
);

   typedef enum logic [1:0] {IDLE, LEER, SALIDA} estado_t;

   localparam logic WRAP = (MODO_WRAP != 0);

   estado_t          r_estado, w_sig;
   logic [AW-1:0]    r_dir;
   logic [LW-1:0]    r_rest;
   logic [ANCHO-1:0] r_datos;
   logic             r_valido, r_fin, r_ocupado, r_error;
   logic             w_captura, w_leer, w_acepta, w_ultimo, w_fuera;
   logic [31:0]      w_dir32, w_idx;
   logic [ANCHO-1:0] w_dato;

   function automatic logic [ANCHO-1:0] rom_leer(input logic [31:0] idx);
      logic [7:0] v;
      case (idx)
         32'd0:   v = 8'd95;
         32'd1:   v = 8'd90;
         32'd2:   v = 8'd96;
         32'd3:   v = 8'd98;
         32'd4:   v = 8'd93;
         32'd5:   v = 8'd94;
         32'd6:   v = 8'd97;
         32'd7:   v = 8'd103;
         32'd8:   v = 8'd56;
         32'd9:   v = 8'd97;
         32'd10:  v = 8'd77;
         default: v = 8'd0;
      endcase
      return ANCHO'(v);
   endfunction

   assign w_ultimo = (r_rest == LW'(1));
   assign w_dir32  = 32'(r_dir);
   assign w_fuera  = (w_dir32 >= 32'(PROFUNDIDAD));
   // Wrap mode folds any counter value back into the table; otherwise out-of-range reads 0.
   assign w_idx    = WRAP ? (w_dir32 % 32'(PROFUNDIDAD)) : w_dir32;
   assign w_dato   = (w_fuera && !WRAP) ? '0 : rom_leer(w_idx);

   always_ff @(posedge clk) begin
      if (!rst_n) r_estado <= IDLE;
      else        r_estado <= w_sig;
   end

   always_comb begin
      w_sig     = r_estado;
      w_captura = 1'b0;
      w_leer    = 1'b0;
      w_acepta  = 1'b0;
      case (r_estado)
         IDLE: if (inicio && longitud != '0) begin
            w_captura = 1'b1;
            w_sig     = LEER;
         end
         LEER: begin
            w_leer = 1'b1;
            w_sig  = SALIDA;
         end
         SALIDA: if (listo) begin
            w_acepta = 1'b1;
            w_sig    = w_ultimo ? IDLE : LEER;
         end
         default: w_sig = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dir     <= '0;
         r_rest    <= '0;
         r_datos   <= '0;
         r_valido  <= 1'b0;
         r_fin     <= 1'b0;
         r_ocupado <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         if (w_captura) begin
            r_dir     <= direccion;
            r_rest    <= longitud;
            r_error   <= 1'b0;
            r_ocupado <= 1'b1;
         end
         if (w_leer) begin
            r_datos  <= w_dato;
            r_valido <= 1'b1;
            r_fin    <= w_ultimo;
            if (w_fuera && !WRAP) r_error <= 1'b1;
         end
         if (w_acepta) begin
            r_valido <= 1'b0;
            r_fin    <= 1'b0;
            if (w_ultimo) r_ocupado <= 1'b0;
            else begin
               r_dir  <= r_dir + AW'(1);
               r_rest <= r_rest - LW'(1);
            end
         end
      end
   end

`ifdef ROM_BURST_SUMA_EN
   logic [15:0] r_suma;
   always_ff @(posedge clk) begin
      if (!rst_n)        r_suma <= '0;
      else if (w_captura) r_suma <= '0;
      else if (w_acepta)  r_suma <= r_suma + 16'(r_datos);
   end
   assign suma = r_suma;
`endif

   assign datos_s = r_datos;
   assign valido  = r_valido;
   assign fin     = r_fin;
   assign ocupado = r_ocupado;
   assign error   = r_error;

endmodule

// File: tb/tb_rom_burst.sv
// Random and directed bursts against a table model, run on a non-wrapping and
// a wrapping instance in lockstep (shared handshake, different data).
module tb_rom_burst;
   logic       clk = 1'b0;
   logic       rst_n, inicio, listo;
   logic [7:0] direccion, longitud;
   logic [7:0] d_nw, d_w;
   logic       v_nw, v_w, f_nw, f_w, o_nw, o_w, e_nw, e_w;
`ifdef ROM_BURST_SUMA_EN
   logic [15:0] s_nw, s_w;
`endif

   int checks = 0;
   int failures = 0;
   int rom [11] = '{95, 90, 96, 98, 93, 94, 97, 103, 56, 97, 77};
   int err_nw;
   logic [15:0] sum_nw, sum_w;

   always #5 clk = ~clk;

   rom_burst #(.MODO_WRAP(0)) u_nw (
      .clk(clk), .rst_n(rst_n), .inicio(inicio), .direccion(direccion),
      .longitud(longitud), .listo(listo), .datos_s(d_nw), .valido(v_nw),
      .fin(f_nw), .ocupado(o_nw), .error(e_nw)
`ifdef ROM_BURST_SUMA_EN
      , .suma(s_nw)
`endif
   );

   rom_burst #(.MODO_WRAP(1)) u_w (
      .clk(clk), .rst_n(rst_n), .inicio(inicio), .direccion(direccion),
      .longitud(longitud), .listo(listo), .datos_s(d_w), .valido(v_w),
      .fin(f_w), .ocupado(o_w), .error(e_w)
`ifdef ROM_BURST_SUMA_EN
      , .suma(s_w)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_d_nw"}, d_nw, 0); chk({tag, "_d_w"}, d_w, 0);
      chk({tag, "_v_nw"}, v_nw, 0); chk({tag, "_v_w"}, v_w, 0);
      chk({tag, "_f_nw"}, f_nw, 0); chk({tag, "_f_w"}, f_w, 0);
      chk({tag, "_o_nw"}, o_nw, 0); chk({tag, "_o_w"}, o_w, 0);
      chk({tag, "_e_nw"}, e_nw, 0); chk({tag, "_e_w"}, e_w, 0);
`ifdef ROM_BURST_SUMA_EN
      chk({tag, "_s_nw"}, s_nw, 0); chk({tag, "_s_w"}, s_w, 0);
`endif
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!v_nw && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("vld_nw", v_nw, 1);
      chk("vld_w", v_w, 1);
   endtask

   // stall0: listo-low cycles on the first beat; smax: random stall bound for others.
   task automatic run_burst(input int base, input int len, input int stall0, input int smax);
      int a, x_nw, x_w, s;
      @(negedge clk);
      inicio = 1'b1; direccion = base[7:0]; longitud = len[7:0];
      @(negedge clk);
      inicio = 1'b0;
      err_nw = 0; sum_nw = '0; sum_w = '0;
      chk("busy_nw", o_nw, 1); chk("busy_w", o_w, 1);
      chk("err_clr", e_nw, 0);
      for (int k = 0; k < len; k++) begin
         a    = (base + k) % 256;
         x_nw = (a < 11) ? rom[a] : 0;
         x_w  = rom[a % 11];
         if (a >= 11) err_nw = 1;
         wait_valid();
         s = (k == 0) ? stall0 : ((smax > 0) ? int'($urandom_range(smax, 0)) : 0);
         for (int j = 0; j <= s; j++) begin
            chk("data_nw", d_nw, x_nw); chk("data_w", d_w, x_w);
            chk("vhold_nw", v_nw, 1);
            chk("fin_nw", f_nw, (k == len - 1)); chk("fin_w", f_w, (k == len - 1));
            chk("err_nw", e_nw, err_nw); chk("err_w", e_w, 0);
            if (j < s) begin
               // inicio while busy must be ignored
               inicio = 1'($urandom_range(1, 0));
               direccion = 8'($urandom); longitud = 8'($urandom);
               @(negedge clk);
            end
         end
         inicio = 1'b0; listo = 1'b1;
         @(negedge clk);
         listo = 1'b0;
         sum_nw = sum_nw + 16'(x_nw);
         sum_w  = sum_w + 16'(x_w);
         chk("gap_nw", v_nw, 0);
`ifdef ROM_BURST_SUMA_EN
         chk("sum_nw", s_nw, sum_nw); chk("sum_w", s_w, sum_w);
`endif
      end
      chk("end_busy_nw", o_nw, 0); chk("end_busy_w", o_w, 0);
      chk("end_fin_nw", f_nw, 0);
      chk("end_err_nw", e_nw, err_nw); chk("end_err_w", e_w, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; inicio = 1'b0; listo = 1'b0; direccion = '0; longitud = '0;
      repeat (2) @(negedge clk);
      chk_idle_zero("rst");
      rst_n = 1'b1;

      run_burst(0, 3, 0, 0);
      run_burst(6, 2, 5, 0);
      run_burst(9, 4, 0, 0);

      // zero-length start: no effect, sticky error survives
      @(negedge clk);
      inicio = 1'b1; direccion = 8'd0; longitud = 8'd0;
      @(negedge clk);
      inicio = 1'b0;
      chk("len0_busy", o_nw, 0); chk("len0_err", e_nw, 1);

      run_burst(254, 4, 1, 2);
      run_burst(0, 11, 0, 2);
`ifdef ROM_BURST_SUMA_EN
      chk("sum_full", s_nw, 996);
`endif

      // reset during second beat of a 5-beat burst
      @(negedge clk);
      inicio = 1'b1; direccion = 8'd2; longitud = 8'd5;
      @(negedge clk);
      inicio = 1'b0;
      wait_valid();
      listo = 1'b1;
      @(negedge clk);
      listo = 1'b0;
      wait_valid();
      chk("rst_b2_data", d_nw, 98);
      rst_n = 1'b0;
      @(negedge clk);
      chk_idle_zero("midrst");
      rst_n = 1'b1; listo = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_vld", v_nw, 0); chk("post_rst_busy", o_w, 0);
      end
      listo = 1'b0;
      inicio = 1'b1; longitud = 8'd0;
      @(negedge clk);
      inicio = 1'b0;
      @(negedge clk);
      chk("rst_len0_busy", o_nw, 0); chk("rst_len0_vld", v_w, 0);

      for (int i = 0; i < 30; i++)
         run_burst(int'($urandom_range(255, 0)), int'($urandom_range(12, 1)), int'($urandom_range(2, 0)), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
